// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - pipeline-side signal bundle for the hazard/stall unit
//
// Purpose: groups every pipeline status input and every stall/flush/status
// output of hazard_stall_unit so the core and the unit share one connection.
//   slave  modport : used by hazard_stall_unit (status in, control out)
//   master modport : used by the pipeline (status out, control in)
// Status (pipeline -> unit):
//   ifid_valid, ifid_rs1[4:0], ifid_rs2[4:0], ifid_uses_rs2   instruction in ID
//   idex_valid, idex_rd[4:0], idex_is_load                    instruction in EX
//   memwb_valid, memwb_rd[4:0], memwb_writes                  instruction in WB
//   exmem_mem_req, dmem_ready                                 MEM-stage access
//   ex_branch_taken                                           taken branch in EX
// Control / status (unit -> pipeline):
//   stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb
//   bubble_idex, flush_ifid, mem_timeout
//   stall_cycles[31:0], bubble_count[31:0]
interface hazard_stall_unit_if;
    logic        ifid_valid;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        ifid_uses_rs2;
    logic        idex_valid;
    logic [4:0]  idex_rd;
    logic        idex_is_load;
    logic        memwb_valid;
    logic [4:0]  memwb_rd;
    logic        memwb_writes;
    logic        exmem_mem_req;
    logic        dmem_ready;
    logic        ex_branch_taken;

    logic        stall_pc;
    logic        stall_ifid;
    logic        stall_idex;
    logic        stall_exmem;
    logic        stall_memwb;
    logic        bubble_idex;
    logic        flush_ifid;
    logic        mem_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] bubble_count;

    modport master (
        output ifid_valid, ifid_rs1, ifid_rs2, ifid_uses_rs2,
        output idex_valid, idex_rd, idex_is_load,
        output memwb_valid, memwb_rd, memwb_writes,
        output exmem_mem_req, dmem_ready, ex_branch_taken,
        input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
        input  bubble_idex, flush_ifid, mem_timeout,
        input  stall_cycles, bubble_count
    );

    modport slave (
        input  ifid_valid, ifid_rs1, ifid_rs2, ifid_uses_rs2,
        input  idex_valid, idex_rd, idex_is_load,
        input  memwb_valid, memwb_rd, memwb_writes,
        input  exmem_mem_req, dmem_ready, ex_branch_taken,
        output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
        output bubble_idex, flush_ifid, mem_timeout,
        output stall_cycles, bubble_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - 5-stage pipeline hazard detection, stall/flush control and memory-wait watchdog
//
// Purpose: decides each cycle whether the pipeline freezes (data memory not
// ready), flushes (taken branch), or inserts a load-use / WB-read bubble.
// Tracks memory-wait length and raises a sticky timeout flag, and counts
// stall and bubble cycles.
// Parameters:
//   MEM_TIMEOUT      wait cycles after which mem_timeout asserts (1..65535)
//   WB_DECODE_STALL  1: ID reads of the WB destination stall (no ID bypass)
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   hz     hazard_stall_unit_if.slave, all pipeline status and control
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter bit          WB_DECODE_STALL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_stall_unit_if.slave   hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_e;

    // wait_cnt counts completed wait cycles, so the cycle that sees
    // MEM_TIMEOUT-1 is the MEM_TIMEOUT-th consecutive wait cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    logic mem_wait;
    logic load_use;
    logic wb_use;
    logic timeout_hit;

    logic stall_pc;
    logic stall_ifid;
    logic stall_idex;
    logic stall_exmem;
    logic stall_memwb;
    logic bubble_idex;
    logic flush_ifid;

    // ------------------------------------------------------------------
    // Hazard terms
    // ------------------------------------------------------------------
    always_comb begin
        mem_wait = hz.exmem_mem_req && !hz.dmem_ready;

        // x0 never carries data, so a load targeting it cannot create a hazard.
        load_use = hz.idex_valid && hz.idex_is_load && (hz.idex_rd != 5'd0) &&
                   hz.ifid_valid &&
                   ((hz.idex_rd == hz.ifid_rs1) ||
                    (hz.ifid_uses_rs2 && (hz.idex_rd == hz.ifid_rs2)));

        wb_use = 1'b0;
        if (WB_DECODE_STALL) begin
            wb_use = hz.memwb_valid && hz.memwb_writes && (hz.memwb_rd != 5'd0) &&
                     hz.ifid_valid &&
                     ((hz.memwb_rd == hz.ifid_rs1) ||
                      (hz.ifid_uses_rs2 && (hz.memwb_rd == hz.ifid_rs2)));
        end
    end

    // ------------------------------------------------------------------
    // Control outputs: purely combinational, priority freeze > flush > bubble.
    // One load-use bubble is enough; the consumer then picks the loaded value
    // up through the EX-stage bypass from WB, so no second bubble is issued.
    // ------------------------------------------------------------------
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        stall_memwb = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;

        if (!rst_n) begin
            // hold everything quiet while in reset, whatever the inputs
        end else if (mem_wait) begin
            // full freeze; a taken branch is re-presented once memory completes
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            stall_memwb = 1'b1;
        end else if (hz.ex_branch_taken) begin
            // the flushed ID instruction makes any load-use match irrelevant
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end else if (load_use || wb_use) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM and watchdog
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timeout_hit = mem_wait && (wait_cnt_q == TIMEOUT_LAST);

        // saturate so a stuck memory cannot wrap the counter back to the
        // threshold and misreport a second timeout edge
        if (!mem_wait) begin
            wait_cnt_d = 16'd0;
        end else if (wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        unique case (state_q)
            ST_RUN: begin
                // RUN can only hit the threshold when MEM_TIMEOUT is 1
                if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end else if (mem_wait) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                // leaving on dropped request as well keeps the FSM from
                // parking in a wait state that no longer exists
                if (!mem_wait) begin
                    state_d = ST_RUN;
                end else if (timeout_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                if (!mem_wait) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        mem_timeout_d = mem_timeout_q ||
                        ((state_d == ST_TIMEOUT) && (state_q != ST_TIMEOUT));
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        bubble_count_d = bubble_count_q;
        if (stall_pc && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (bubble_idex && (bubble_count_q != CNT_MAX)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= 16'd0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= 32'd0;
            bubble_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hz.stall_pc     = stall_pc;
    assign hz.stall_ifid   = stall_ifid;
    assign hz.stall_idex   = stall_idex;
    assign hz.stall_exmem  = stall_exmem;
    assign hz.stall_memwb  = stall_memwb;
    assign hz.bubble_idex  = bubble_idex;
    assign hz.flush_ifid   = flush_ifid;
    assign hz.mem_timeout  = mem_timeout_q;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.bubble_count = bubble_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - directed scoreboard bench for hazard_stall_unit
module tb_hazard_stall_unit;

    typedef struct packed {
        logic       rst_n;
        logic       ifid_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs2;
        logic       idex_valid;
        logic [4:0] idex_rd;
        logic       idex_is_load;
        logic       memwb_valid;
        logic [4:0] memwb_rd;
        logic       memwb_writes;
        logic       mem_req;
        logic       dmem_ready;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctrl_a;
        logic [6:0]  ctrl_b;
        logic        to;
        logic [31:0] sc_a;
        logic [31:0] bc_a;
        logic [31:0] sc_b;
        logic [31:0] bc_b;
    } exp_t;

    // {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb, bubble_idex, flush_ifid}
    localparam logic [6:0] K_NONE   = 7'b00000_00;
    localparam logic [6:0] K_LU     = 7'b11000_10;
    localparam logic [6:0] K_BR     = 7'b00000_11;
    localparam logic [6:0] K_FREEZE = 7'b11111_00;

    logic clk;
    logic rst_n;

    hazard_stall_unit_if bus_a ();
    hazard_stall_unit_if bus_b ();

    hazard_stall_unit #(.MEM_TIMEOUT(4), .WB_DECODE_STALL(1'b0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_a.slave)
    );

    hazard_stall_unit #(.MEM_TIMEOUT(4), .WB_DECODE_STALL(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stim_t       cur;
    exp_t        sb_q[$];
    int          checks;
    int          passed;
    int          fails;
    int          step_no;
    logic [31:0] msc_a, mbc_a, msc_b, mbc_b;

    task automatic drive();
        rst_n               = cur.rst_n;
        bus_a.ifid_valid    = cur.ifid_valid;    bus_b.ifid_valid    = cur.ifid_valid;
        bus_a.ifid_rs1      = cur.rs1;           bus_b.ifid_rs1      = cur.rs1;
        bus_a.ifid_rs2      = cur.rs2;           bus_b.ifid_rs2      = cur.rs2;
        bus_a.ifid_uses_rs2 = cur.uses_rs2;      bus_b.ifid_uses_rs2 = cur.uses_rs2;
        bus_a.idex_valid    = cur.idex_valid;    bus_b.idex_valid    = cur.idex_valid;
        bus_a.idex_rd       = cur.idex_rd;       bus_b.idex_rd       = cur.idex_rd;
        bus_a.idex_is_load  = cur.idex_is_load;  bus_b.idex_is_load  = cur.idex_is_load;
        bus_a.memwb_valid   = cur.memwb_valid;   bus_b.memwb_valid   = cur.memwb_valid;
        bus_a.memwb_rd      = cur.memwb_rd;      bus_b.memwb_rd      = cur.memwb_rd;
        bus_a.memwb_writes  = cur.memwb_writes;  bus_b.memwb_writes  = cur.memwb_writes;
        bus_a.exmem_mem_req = cur.mem_req;       bus_b.exmem_mem_req = cur.mem_req;
        bus_a.dmem_ready    = cur.dmem_ready;    bus_b.dmem_ready    = cur.dmem_ready;
        bus_a.ex_branch_taken = cur.br;          bus_b.ex_branch_taken = cur.br;
    endtask

    task automatic idle();
        logic keep_rst;
        keep_rst       = cur.rst_n;
        cur            = '0;
        cur.rst_n      = keep_rst;
        cur.dmem_ready = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL step %0d %s observed=%h expected=%h", step_no, tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue what both units
    // must show, then sample 1 ns later and retire the queued expectation.
    task automatic step(input logic [6:0] ea, input logic [6:0] eb, input logic eto);
        exp_t e;
        @(negedge clk);
        step_no++;
        drive();
        if (!cur.rst_n) begin
            msc_a = 0; mbc_a = 0; msc_b = 0; mbc_b = 0;
        end
        e.ctrl_a = ea;    e.ctrl_b = eb;    e.to = eto;
        e.sc_a   = msc_a; e.bc_a   = mbc_a;
        e.sc_b   = msc_b; e.bc_b   = mbc_b;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        chk("ctrl_a", 32'({bus_a.stall_pc, bus_a.stall_ifid, bus_a.stall_idex, bus_a.stall_exmem,
                          bus_a.stall_memwb, bus_a.bubble_idex, bus_a.flush_ifid}), 32'(e.ctrl_a));
        chk("ctrl_b", 32'({bus_b.stall_pc, bus_b.stall_ifid, bus_b.stall_idex, bus_b.stall_exmem,
                          bus_b.stall_memwb, bus_b.bubble_idex, bus_b.flush_ifid}), 32'(e.ctrl_b));
        chk("mem_timeout_a", 32'(bus_a.mem_timeout), 32'(e.to));
        chk("mem_timeout_b", 32'(bus_b.mem_timeout), 32'(e.to));
        chk("stall_cycles_a", bus_a.stall_cycles, e.sc_a);
        chk("bubble_count_a", bus_a.bubble_count, e.bc_a);
        chk("stall_cycles_b", bus_b.stall_cycles, e.sc_b);
        chk("bubble_count_b", bus_b.bubble_count, e.bc_b);
        if (cur.rst_n) begin
            if (ea[6]) msc_a++;
            if (ea[1]) mbc_a++;
            if (eb[6]) msc_b++;
            if (eb[1]) mbc_b++;
        end
    endtask

    initial begin
        checks = 0; passed = 0; fails = 0; step_no = 0;
        msc_a = 0; mbc_a = 0; msc_b = 0; mbc_b = 0;
        cur = '0;
        cur.dmem_ready = 1'b1;
        drive();

        // reset with every hazard active: outputs quiet
        cur.mem_req = 1'b1; cur.dmem_ready = 1'b0; cur.br = 1'b1;
        cur.idex_valid = 1'b1; cur.idex_is_load = 1'b1; cur.idex_rd = 5'd5;
        cur.ifid_valid = 1'b1; cur.rs1 = 5'd5;
        step(K_NONE, K_NONE, 1'b0);
        step(K_NONE, K_NONE, 1'b0);

        cur.rst_n = 1'b1;
        idle();
        step(K_NONE, K_NONE, 1'b0);

        // load-use rd=5 / rs1=5: one bubble, then the bubble clears the hazard
        cur.idex_valid = 1'b1; cur.idex_is_load = 1'b1; cur.idex_rd = 5'd5;
        cur.ifid_valid = 1'b1; cur.rs1 = 5'd5;
        step(K_LU, K_LU, 1'b0);
        cur.idex_valid = 1'b0;
        step(K_NONE, K_NONE, 1'b0);

        // rd=0 never stalls
        cur.idex_valid = 1'b1; cur.idex_rd = 5'd0; cur.rs1 = 5'd0;
        step(K_NONE, K_NONE, 1'b0);

        // rs2 match only counts when rs2 is used
        cur.idex_rd = 5'd6; cur.rs1 = 5'd1; cur.rs2 = 5'd6; cur.uses_rs2 = 1'b0;
        step(K_NONE, K_NONE, 1'b0);
        cur.uses_rs2 = 1'b1;
        step(K_LU, K_LU, 1'b0);

        // invalid ID slot, and non-load producer
        cur.ifid_valid = 1'b0;
        step(K_NONE, K_NONE, 1'b0);
        cur.ifid_valid = 1'b1; cur.idex_is_load = 1'b0;
        step(K_NONE, K_NONE, 1'b0);

        // taken branch overrides a load-use match
        cur.idex_is_load = 1'b1; cur.br = 1'b1;
        step(K_BR, K_BR, 1'b0);

        // three memory-wait cycles: full freeze, branch and load-use ignored
        cur.mem_req = 1'b1; cur.dmem_ready = 1'b0;
        step(K_FREEZE, K_FREEZE, 1'b0);
        step(K_FREEZE, K_FREEZE, 1'b0);
        step(K_FREEZE, K_FREEZE, 1'b0);
        // request completing this cycle is not a stall; branch now acts
        cur.dmem_ready = 1'b1;
        step(K_BR, K_BR, 1'b0);
        idle();
        step(K_NONE, K_NONE, 1'b0);

        // WB-stage read of rd=7 through rs2: only the WB_DECODE_STALL unit stalls
        cur.memwb_valid = 1'b1; cur.memwb_rd = 5'd7; cur.memwb_writes = 1'b1;
        cur.ifid_valid = 1'b1; cur.rs1 = 5'd2; cur.rs2 = 5'd7; cur.uses_rs2 = 1'b1;
        step(K_NONE, K_LU, 1'b0);
        cur.memwb_valid = 1'b0;
        step(K_NONE, K_NONE, 1'b0);
        cur.memwb_valid = 1'b1; cur.memwb_writes = 1'b0;
        step(K_NONE, K_NONE, 1'b0);
        cur.memwb_writes = 1'b1; cur.memwb_rd = 5'd0; cur.rs2 = 5'd0;
        step(K_NONE, K_NONE, 1'b0);

        // timeout: MEM_TIMEOUT=4, six wait cycles, flag visible after the 4th
        idle();
        cur.mem_req = 1'b1; cur.dmem_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(K_FREEZE, K_FREEZE, (i >= 5) ? 1'b1 : 1'b0);
        end
        cur.dmem_ready = 1'b1;
        step(K_NONE, K_NONE, 1'b1);
        idle();
        step(K_NONE, K_NONE, 1'b1);

        // new wait then reset mid-cycle: state, flag and counters clear at once
        cur.mem_req = 1'b1; cur.dmem_ready = 1'b0;
        step(K_FREEZE, K_FREEZE, 1'b1);
        step(K_FREEZE, K_FREEZE, 1'b1);
        cur.rst_n = 1'b0;
        step(K_NONE, K_NONE, 1'b0);
        cur.rst_n = 1'b1;
        idle();
        step(K_NONE, K_NONE, 1'b0);
        // a fresh wait after reset freezes without a stale timeout
        cur.mem_req = 1'b1; cur.dmem_ready = 1'b0;
        step(K_FREEZE, K_FREEZE, 1'b0);
        idle();
        step(K_NONE, K_NONE, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
